// File: rtl/alu_mc_if.sv
// alu_mc_if
//   Bundles the EX-stage ALU handshake and datapath signals.
//   master : pipeline side (drives op, operands, branch prediction, flush)
//   slave  : ALU side (drives busy, out_valid, result, branch resolution)
//   Signals:
//     EX_valid, EX_flush           op presented / kill in-flight work
//     EX_a, EX_b                   operands (PC and offset for branches)
//     EX_a2, EX_b2                 branch compare operands
//     EX_alu_op, EX_brn            opcode, branch/jump flag
//     EX_BP_taken, EX_BP_target_pc predictor outcome and target
//     EX_busy, EX_out_valid        stall request, 1-cycle result strobe
//     EX_alu_out                   result or resolved next PC
//     EX_taken, EX_true_taken      mispredict flag, actual branch outcome
interface alu_mc_if #(
    parameter int XLEN     = 32,
    parameter int VPC_BITS = 32
);
    logic                EX_valid;
    logic                EX_flush;
    logic [XLEN-1:0]     EX_a;
    logic [XLEN-1:0]     EX_b;
    logic [XLEN-1:0]     EX_a2;
    logic [XLEN-1:0]     EX_b2;
    logic [3:0]          EX_alu_op;
    logic                EX_brn;
    logic                EX_BP_taken;
    logic [VPC_BITS-1:0] EX_BP_target_pc;
    logic                EX_busy;
    logic                EX_out_valid;
    logic [XLEN-1:0]     EX_alu_out;
    logic                EX_taken;
    logic                EX_true_taken;

    modport master (
        output EX_valid, EX_flush, EX_a, EX_b, EX_a2, EX_b2,
               EX_alu_op, EX_brn, EX_BP_taken, EX_BP_target_pc,
        input  EX_busy, EX_out_valid, EX_alu_out, EX_taken, EX_true_taken
    );

    modport slave (
        input  EX_valid, EX_flush, EX_a, EX_b, EX_a2, EX_b2,
               EX_alu_op, EX_brn, EX_BP_taken, EX_BP_target_pc,
        output EX_busy, EX_out_valid, EX_alu_out, EX_taken, EX_true_taken
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc
//   Multi-cycle execute-stage ALU. Single-cycle ops and branches register
//   their result one cycle after accept; mul (unless MUL_FAST), divu and
//   remu iterate one bit per cycle and register after XLEN+1 cycles.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     ex     alu_mc_if.slave bundle (handshake, operands, results)
module alu_mc #(
    parameter int XLEN     = 32,
    parameter int VPC_BITS = 32,
    parameter int MUL_FAST = 0
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave ex
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOTA = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_EQ   = 4'b1000;
    localparam logic [3:0] OP_LTU  = 4'b1001;
    localparam logic [3:0] OP_GTU  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;
    localparam logic [3:0] OP_SRA  = 4'b1110;
    localparam logic [3:0] OP_SLT  = 4'b1111;

    logic [1:0]      r_state;
    logic [SHW-1:0]  r_cnt;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_acc;   // product accumulator / partial remainder
    logic [XLEN-1:0] r_opa;   // multiplier (shifts right) / dividend->quotient
    logic [XLEN-1:0] r_opb;   // multiplicand (shifts left) / divisor
    logic            r_out_valid;
    logic [XLEN-1:0] r_alu_out;
    logic            r_taken;
    logic            r_true_taken;

    logic            w_accept;
    logic            w_iter;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_sc_result;
    logic            w_outcome;
    logic [XLEN-1:0] w_next_pc;
    logic            w_mispredict;
    logic [XLEN-1:0] w_mul_acc;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_nxt_acc;
    logic [XLEN-1:0] w_nxt_opa;
    logic [XLEN-1:0] w_nxt_opb;
    logic [XLEN-1:0] w_iter_result;

    assign w_accept = ex.EX_valid && (r_state == S_IDLE) && !ex.EX_flush;
    assign w_iter   = !ex.EX_brn &&
                      (((ex.EX_alu_op == OP_MUL) && (MUL_FAST == 0)) ||
                       (ex.EX_alu_op == OP_DIVU) || (ex.EX_alu_op == OP_REMU));
    assign w_shamt  = ex.EX_b[SHW-1:0];
    assign w_prod   = ex.EX_a * ex.EX_b;

    always_comb begin
        w_sc_result = '0;
        case (ex.EX_alu_op)
            OP_ADD:  w_sc_result = ex.EX_a + ex.EX_b;
            OP_SUB:  w_sc_result = ex.EX_a - ex.EX_b;
            OP_AND:  w_sc_result = ex.EX_a & ex.EX_b;
            OP_OR:   w_sc_result = ex.EX_a | ex.EX_b;
            OP_XOR:  w_sc_result = ex.EX_a ^ ex.EX_b;
            OP_NOTA: w_sc_result = ~ex.EX_a;
            OP_SLL:  w_sc_result = ex.EX_a << w_shamt;
            OP_SRL:  w_sc_result = ex.EX_a >> w_shamt;
            OP_EQ:   w_sc_result = {{(XLEN-1){1'b0}}, ex.EX_a == ex.EX_b};
            OP_LTU:  w_sc_result = {{(XLEN-1){1'b0}}, ex.EX_a < ex.EX_b};
            OP_GTU:  w_sc_result = {{(XLEN-1){1'b0}}, ex.EX_a > ex.EX_b};
            OP_MUL:  w_sc_result = w_prod;
            OP_SRA:  w_sc_result = $unsigned($signed(ex.EX_a) >>> w_shamt);
            OP_SLT:  w_sc_result = {{(XLEN-1){1'b0}},
                                    $signed(ex.EX_a) < $signed(ex.EX_b)};
            default: w_sc_result = '0;
        endcase
    end

    always_comb begin
        case (ex.EX_alu_op)
            OP_EQ:   w_outcome = (ex.EX_a2 == ex.EX_b2);
            OP_LTU:  w_outcome = (ex.EX_a2 <  ex.EX_b2);
            OP_GTU:  w_outcome = (ex.EX_a2 >  ex.EX_b2);
            OP_MUL:  w_outcome = (ex.EX_a2 != ex.EX_b2);
            default: w_outcome = 1'b1;
        endcase
    end

    assign w_next_pc    = w_outcome ? (ex.EX_a + ex.EX_b) : (ex.EX_a + XLEN'(4));
    assign w_mispredict = (ex.EX_BP_taken != w_outcome) ||
                          (ex.EX_BP_target_pc != w_next_pc[VPC_BITS-1:0]);

    // One iteration of shift-add multiply or restoring divide. The remainder
    // stays below the divisor, so XLEN bits hold it after each restore; with
    // a zero divisor every trial subtract succeeds, which yields all-ones
    // quotient and a remainder equal to the dividend without a special case.
    assign w_mul_acc = r_acc + (r_opa[0] ? r_opb : '0);
    assign w_rem_sh  = {r_acc, r_opa[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opb};
    assign w_ge      = !w_diff[XLEN];

    always_comb begin
        if (r_op == OP_MUL) begin
            w_nxt_acc = w_mul_acc;
            w_nxt_opa = r_opa >> 1;
            w_nxt_opb = r_opb << 1;
        end else begin
            w_nxt_acc = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
            w_nxt_opa = {r_opa[XLEN-2:0], w_ge};
            w_nxt_opb = r_opb;
        end
    end

    assign w_iter_result = (r_op == OP_DIVU) ? w_nxt_opa : w_nxt_acc;

    // RUN performs XLEN-1 iterations and DONE performs the last one while
    // registering the result, so busy spans exactly XLEN cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_op         <= '0;
            r_acc        <= '0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_out_valid  <= 1'b0;
            r_alu_out    <= '0;
            r_taken      <= 1'b0;
            r_true_taken <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (ex.EX_flush) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            if (ex.EX_brn) begin
                                r_alu_out    <= w_next_pc;
                                r_taken      <= w_mispredict;
                                r_true_taken <= w_outcome;
                                r_out_valid  <= 1'b1;
                            end else if (w_iter) begin
                                r_op    <= ex.EX_alu_op;
                                r_acc   <= '0;
                                r_opa   <= ex.EX_a;
                                r_opb   <= ex.EX_b;
                                r_cnt   <= SHW'(XLEN-1);
                                r_state <= S_RUN;
                            end else begin
                                r_alu_out    <= w_sc_result;
                                r_taken      <= 1'b0;
                                r_true_taken <= 1'b0;
                                r_out_valid  <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        r_acc <= w_nxt_acc;
                        r_opa <= w_nxt_opa;
                        r_opb <= w_nxt_opb;
                        r_cnt <= r_cnt - SHW'(1);
                        if (r_cnt == SHW'(1)) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_alu_out    <= w_iter_result;
                        r_taken      <= 1'b0;
                        r_true_taken <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ex.EX_busy       = (r_state != S_IDLE);
    assign ex.EX_out_valid  = r_out_valid;
    assign ex.EX_alu_out    = r_alu_out;
    assign ex.EX_taken      = r_taken;
    assign ex.EX_true_taken = r_true_taken;
endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_mc_if #(.XLEN(XLEN), .VPC_BITS(XLEN)) bus_s ();
    alu_mc_if #(.XLEN(XLEN), .VPC_BITS(XLEN)) bus_f ();

    alu_mc #(.XLEN(XLEN), .VPC_BITS(XLEN), .MUL_FAST(0)) u_slow (
        .clk(clk), .rst_n(rst_n), .ex(bus_s)
    );
    alu_mc #(.XLEN(XLEN), .VPC_BITS(XLEN), .MUL_FAST(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .ex(bus_f)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        brn;
        logic [31:0] a, b, a2, b2;
        logic        bpt;
        logic [31:0] bptgt;
        logic [31:0] exp_out;
        logic        exp_tk, exp_tt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic [3:0] op, input logic brn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] a2, input logic [31:0] b2,
                         input logic bpt, input logic [31:0] bptgt);
        bus_s.EX_valid = v;   bus_f.EX_valid = v;
        bus_s.EX_flush = fl;  bus_f.EX_flush = fl;
        bus_s.EX_alu_op = op; bus_f.EX_alu_op = op;
        bus_s.EX_brn = brn;   bus_f.EX_brn = brn;
        bus_s.EX_a = a;       bus_f.EX_a = a;
        bus_s.EX_b = b;       bus_f.EX_b = b;
        bus_s.EX_a2 = a2;     bus_f.EX_a2 = a2;
        bus_s.EX_b2 = b2;     bus_f.EX_b2 = b2;
        bus_s.EX_BP_taken = bpt;       bus_f.EX_BP_taken = bpt;
        bus_s.EX_BP_target_pc = bptgt; bus_f.EX_BP_target_pc = bptgt;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, '0, '0, 1'b0, '0);
    endtask

    // Reference behaviour from the opcode table, using plain arithmetic.
    function automatic void model(input logic [3:0] op, input logic brn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] a2, input logic [31:0] b2,
                                  input logic bpt, input logic [31:0] bptgt,
                                  output logic [31:0] r, output logic tk, output logic tt);
        logic [4:0]  sh;
        logic        outc;
        logic [31:0] np;
        sh = b[4:0];
        tk = 1'b0;
        tt = 1'b0;
        if (brn) begin
            case (op)
                4'd8:    outc = (a2 == b2);
                4'd9:    outc = (a2 < b2);
                4'd10:   outc = (a2 > b2);
                4'd11:   outc = (a2 != b2);
                default: outc = 1'b1;
            endcase
            np = outc ? a + b : a + 32'd4;
            r  = np;
            tt = outc;
            tk = (bpt != outc) || (bptgt != np);
        end else begin
            case (op)
                4'd0:  r = a + b;
                4'd1:  r = a - b;
                4'd2:  r = a & b;
                4'd3:  r = a | b;
                4'd4:  r = a ^ b;
                4'd5:  r = ~a;
                4'd6:  r = a << sh;
                4'd7:  r = a >> sh;
                4'd8:  r = {31'b0, a == b};
                4'd9:  r = {31'b0, a < b};
                4'd10: r = {31'b0, a > b};
                4'd11: r = a * b;
                4'd12: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                4'd13: r = (b == 0) ? a : a % b;
                4'd14: r = $unsigned($signed(a) >>> sh);
                default: r = {31'b0, $signed(a) < $signed(b)};
            endcase
        end
    endfunction

    // Issue one op to both DUTs (called at a negedge with both idle) and
    // check result, branch bits, latency, busy duration and pulse width.
    task automatic do_op(input string nm, input logic [3:0] op, input logic brn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] a2, input logic [31:0] b2,
                         input logic bpt, input logic [31:0] bptgt,
                         input logic [31:0] e_out, input logic e_tk, input logic e_tt);
        int          lat_s = 0, lat_f = 0, busy_cnt = 0;
        bit          got_s = 0, got_f = 0;
        logic [31:0] s_out = '0, f_out = '0;
        logic        s_tk = 1'b0, s_tt = 1'b0;
        int          exp_lat_s, exp_lat_f;
        exp_lat_s = (!brn && (op == 4'd11 || op == 4'd12 || op == 4'd13)) ? XLEN + 1 : 1;
        exp_lat_f = (!brn && (op == 4'd12 || op == 4'd13)) ? XLEN + 1 : 1;
        drive(1'b1, 1'b0, op, brn, a, b, a2, b2, bpt, bptgt);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus_s.EX_busy) busy_cnt++;
            if (!got_s && bus_s.EX_out_valid) begin
                got_s = 1; lat_s = c;
                s_out = bus_s.EX_alu_out; s_tk = bus_s.EX_taken; s_tt = bus_s.EX_true_taken;
            end
            if (!got_f && bus_f.EX_out_valid) begin
                got_f = 1; lat_f = c; f_out = bus_f.EX_alu_out;
            end
            if (c == 1) idle_inputs();
            if (got_s && got_f) break;
        end
        chk({nm, ".out"}, s_out, e_out);
        chk({nm, ".taken"}, 32'(s_tk), 32'(e_tk));
        chk({nm, ".true_taken"}, 32'(s_tt), 32'(e_tt));
        chk({nm, ".latency"}, 32'(lat_s), 32'(exp_lat_s));
        chk({nm, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_lat_s - 1));
        chk({nm, ".fast_out"}, f_out, e_out);
        chk({nm, ".fast_latency"}, 32'(lat_f), 32'(exp_lat_f));
        @(negedge clk);
        chk({nm, ".pulse_end"}, 32'(bus_s.EX_out_valid), 32'd0);
    endtask

    task automatic add_vec(input string nm, input logic [3:0] op, input logic brn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] a2, input logic [31:0] b2,
                           input logic bpt, input logic [31:0] bptgt,
                           input logic [31:0] e, input logic tk, input logic tt);
        vec_t v;
        v.name = nm; v.op = op; v.brn = brn; v.a = a; v.b = b; v.a2 = a2; v.b2 = b2;
        v.bpt = bpt; v.bptgt = bptgt; v.exp_out = e; v.exp_tk = tk; v.exp_tt = tt;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 20));
            1:       return 32'($urandom);
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return 32'h8000_0000 | 32'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        int          pulses;
        logic [31:0] r, tgt;
        logic        tk, tt;
        logic [3:0]  op;
        logic        brn, bpt;
        logic [31:0] a, b, a2, b2;

        add_vec("add",        4'd0,  0, 32'd5, 32'd7, 0, 0, 0, 0, 32'd12, 0, 0);
        add_vec("beq_mispr",  4'd8,  1, 32'h100, 32'h20, 3, 3, 0, 0, 32'h120, 1, 1);
        add_vec("beq_pred",   4'd8,  1, 32'h100, 32'h20, 3, 3, 1, 32'h120, 32'h120, 0, 1);
        add_vec("bne_nt",     4'd11, 1, 32'h100, 32'h20, 3, 3, 0, 32'h104, 32'h104, 0, 0);
        add_vec("blt_badtgt", 4'd9,  1, 32'h200, 32'hFFFF_FFF0, 2, 3, 1, 32'h1F4, 32'h1F0, 1, 1);
        add_vec("jump",       4'd0,  1, 32'h1000, 32'h10, 0, 0, 1, 32'h1010, 32'h1010, 0, 1);
        add_vec("mul",        4'd11, 0, 32'hFFFF_FFFF, 32'd3, 0, 0, 0, 0, 32'hFFFF_FFFD, 0, 0);
        add_vec("mul_ovf",    4'd11, 0, 32'h1_0000, 32'h1_0000, 0, 0, 0, 0, 32'h0, 0, 0);
        add_vec("divu",       4'd12, 0, 32'd100, 32'd7, 0, 0, 0, 0, 32'd14, 0, 0);
        add_vec("remu",       4'd13, 0, 32'd100, 32'd7, 0, 0, 0, 0, 32'd2, 0, 0);
        add_vec("divu_z",     4'd12, 0, 32'd9, 32'd0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
        add_vec("remu_z",     4'd13, 0, 32'd9, 32'd0, 0, 0, 0, 0, 32'd9, 0, 0);
        add_vec("divu_by1",   4'd12, 0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
        add_vec("remu_big",   4'd13, 0, 32'hFFFF_FFFF, 32'h10, 0, 0, 0, 0, 32'hF, 0, 0);
        add_vec("sra",        4'd14, 0, 32'h8000_0000, 32'd4, 0, 0, 0, 0, 32'hF800_0000, 0, 0);
        add_vec("slt",        4'd15, 0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 32'd1, 0, 0);
        add_vec("ltu",        4'd9,  0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 32'd0, 0, 0);
        add_vec("gtu",        4'd10, 0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 32'd1, 0, 0);
        add_vec("sll_mask",   4'd6,  0, 32'd1, 32'h23, 0, 0, 0, 0, 32'd8, 0, 0);
        add_vec("srl_mask",   4'd7,  0, 32'h8000_0000, 32'h21, 0, 0, 0, 0, 32'h4000_0000, 0, 0);
        add_vec("nota",       4'd5,  0, 32'h0F0F_0000, 32'd0, 0, 0, 0, 0, 32'hF0F0_FFFF, 0, 0);

        // Reset held two cycles with a valid op presented.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 4'd0, 1'b0, 32'd5, 32'd7, '0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid", 32'(bus_s.EX_out_valid), 0);
        chk("rst.alu_out", bus_s.EX_alu_out, 0);
        chk("rst.taken", 32'(bus_s.EX_taken), 0);
        chk("rst.true_taken", 32'(bus_s.EX_true_taken), 0);
        chk("rst.busy", 32'(bus_s.EX_busy), 0);
        chk("rst.fast_busy", 32'(bus_f.EX_busy), 0);
        rst_n = 1'b1;
        idle_inputs();

        foreach (vecs[i])
            do_op(vecs[i].name, vecs[i].op, vecs[i].brn, vecs[i].a, vecs[i].b,
                  vecs[i].a2, vecs[i].b2, vecs[i].bpt, vecs[i].bptgt,
                  vecs[i].exp_out, vecs[i].exp_tk, vecs[i].exp_tt);

        // Second op held valid during busy: accepted only when the first result shows.
        drive(1'b1, 1'b0, 4'd12, 1'b0, 32'd100, 32'd7, '0, '0, 1'b0, '0);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 32'd1, 32'd2, '0, '0, 1'b0, '0);
        pulses = 1;
        for (int c = 2; c <= 60 && !bus_s.EX_out_valid; c++) begin
            if (bus_s.EX_out_valid !== 1'b0) break;
            @(negedge clk);
            pulses = c;
        end
        chk("b2b.first_latency", 32'(pulses), XLEN + 1);
        chk("b2b.first_out", bus_s.EX_alu_out, 32'd14);
        @(negedge clk);
        idle_inputs();
        chk("b2b.second_valid", 32'(bus_s.EX_out_valid), 1);
        chk("b2b.second_out", bus_s.EX_alu_out, 32'd3);
        @(negedge clk);
        chk("b2b.single_accept", 32'(bus_s.EX_out_valid), 0);
        chk("b2b.idle", 32'(bus_s.EX_busy), 0);

        // Flush 10 cycles into a divide.
        drive(1'b1, 1'b0, 4'd12, 1'b0, 32'd1000, 32'd3, '0, '0, 1'b0, '0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) idle_inputs();
        end
        bus_s.EX_flush = 1'b1; bus_f.EX_flush = 1'b1;
        @(negedge clk);
        bus_s.EX_flush = 1'b0; bus_f.EX_flush = 1'b0;
        chk("flush.busy", 32'(bus_s.EX_busy), 0);
        chk("flush.out_valid", 32'(bus_s.EX_out_valid), 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus_s.EX_out_valid) pulses++;
        end
        chk("flush.no_pulse", 32'(pulses), 0);
        do_op("sub_after_flush", 4'd1, 1'b0, 32'd2, 32'd5, '0, '0, 1'b0, '0, 32'hFFFF_FFFD, 0, 0);

        // Reset mid-RUN aborts with no result.
        drive(1'b1, 1'b0, 4'd11, 1'b0, 32'd7, 32'd9, '0, '0, 1'b0, '0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) idle_inputs();
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst.busy", 32'(bus_s.EX_busy), 0);
        chk("midrst.alu_out", bus_s.EX_alu_out, 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus_s.EX_out_valid) pulses++;
        end
        chk("midrst.no_pulse", 32'(pulses), 0);

        // Valid together with flush is ignored; outputs hold.
        drive(1'b1, 1'b1, 4'd0, 1'b0, 32'd1, 32'd1, '0, '0, 1'b0, '0);
        @(negedge clk);
        idle_inputs();
        chk("vflush.out_valid", 32'(bus_s.EX_out_valid), 0);
        chk("vflush.busy", 32'(bus_s.EX_busy), 0);
        chk("vflush.hold", bus_s.EX_alu_out, 0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 150; n++) begin
            op  = 4'($urandom_range(0, 15));
            brn = ($urandom_range(0, 3) == 0);
            a   = rnd_val();
            b   = rnd_val();
            a2  = 32'($urandom_range(0, 3));
            b2  = 32'($urandom_range(0, 3));
            bpt = 1'($urandom_range(0, 1));
            model(op, brn, a, b, a2, b2, bpt, '0, r, tk, tt);
            tgt = ($urandom_range(0, 1) == 1) ? r : 32'($urandom);
            model(op, brn, a, b, a2, b2, bpt, tgt, r, tk, tt);
            do_op($sformatf("rnd%0d_op%0d_b%0d", n, op, brn), op, brn, a, b, a2, b2, bpt, tgt,
                  r, tk, tt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised execute-stage ALU for the EX stage. It generalises the single-cycle ALU with several changes. All results are registered. Multiply, divide and remainder are iterative. Two new ops replace redundant encodings. A valid/busy handshake lets the pipeline stall on long ops, and a flush input kills in-flight work. Branch resolution and misprediction detection are kept, and the outputs are now registered alongside the data result.

## Interface
- XLEN, 32: datapath width, ≥ 4.
- VPC_BITS, 32: predicted-target width, ≤ XLEN.
- MUL_FAST, 0: 1 = multiply completes in one cycle; 0 = iterative shift-add.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- EX_valid  in  1  operation presented this cycle.
- EX_flush  in  1  kill any in-flight or presented op.
- EX_a, EX_b  in  XLEN  operands; for branches, PC and offset.
- EX_a2, EX_b2  in  XLEN  branch compare operands.
- EX_alu_op  in  4  opcode.
- EX_brn  in  1  op is a branch/jump.
- EX_BP_taken  in  1  predictor's taken bit.
- EX_BP_target_pc  in  VPC_BITS  predictor's target.
- EX_busy  out  1  ALU is occupied; upstream must hold.
- EX_out_valid  out  1  result registers are valid this cycle (1-cycle pulse).
- EX_alu_out  out  XLEN  result or resolved next PC.
- EX_taken  out  1  mispredict, so flush.
- EX_true_taken  out  1  actual branch outcome.

## Operation
- **Accept:** an op is accepted when EX_valid && !EX_busy && !EX_flush. Operands are captured at accept, so inputs may change afterwards.
- **Non-branch opcodes (unsigned unless stated):**
  - Unchanged: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 not a, 0110 sll, 0111 srl, 1000 eq, 1001 ltu, 1010 gtu.
  - Iterative: 1011 mul (low XLEN bits), 1100 divu, 1101 remu.
  - New: 1110 sra (arithmetic shift right), 1111 slt (signed less-than).
  - Compare ops return 0 or 1 zero-extended. Shift amount is b[$clog2(XLEN)-1:0].
- **Divide by zero:** divu returns all-ones; remu returns a.
- **Branch (EX_brn=1):**
  - Outcome: 1000 a2==b2, 1001 a2<b2, 1010 a2>b2, 1011 a2!=b2; every other opcode is taken.
  - next_pc = taken ? a+b : a+4. EX_alu_out = next_pc.
  - EX_true_taken = the outcome.
  - EX_taken = (EX_BP_taken != outcome) || (EX_BP_target_pc != next_pc[VPC_BITS-1:0]).
  - Branches are always single-cycle.
- **State machine:**
  - IDLE: accept single-cycle op → stay IDLE, result registered.
  - IDLE: accept mul (MUL_FAST=0), divu or remu → RUN, counter = XLEN-1.
  - RUN: one iteration per cycle. Multiply: add when the multiplier LSB is set, then shift. Divide: restoring shift-subtract. At counter 0 → DONE.
  - DONE: result registered, go to IDLE.
- EX_busy = (state != IDLE).
- EX_taken and EX_true_taken are 0 for all non-branch results.

## Timing
- **Reset:** while rst_n=0 at a clock edge:
  - state becomes IDLE, counter 0.
  - EX_out_valid, EX_alu_out, EX_taken, EX_true_taken and EX_busy all become 0.
- **Single-cycle op:** accepted at cycle T → EX_out_valid=1 at T+1 with the result.
- **Iterative op:** accepted at T → EX_busy=1 from T+1 to T+XLEN inclusive; EX_out_valid=1 at T+XLEN+1 with EX_busy=0.
  - A new op may be accepted in that T+XLEN+1 cycle, giving back-to-back issue.
- **Flush:**
  - EX_flush=1 at cycle T forces state to IDLE and EX_out_valid=0 at T+1.
  - A result already showing EX_out_valid at T is not retracted.
  - A result due at T+1 is dropped.
  - EX_valid together with EX_flush is ignored.
- **Outputs between pulses:** EX_alu_out, EX_taken and EX_true_taken hold their last values while EX_out_valid=0. Consumers qualify them with EX_out_valid.
- **Reset mid-RUN:** aborts immediately, with no EX_out_valid pulse.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with EX_valid=1 → all outputs 0, EX_busy=0. First op after release: add 5+7 → EX_alu_out=12 one cycle later, EX_out_valid pulses once.
- **Branch mispredict (XLEN=32):** beq with a2=b2=3, a=0x100, b=0x20, BP_taken=0 → EX_alu_out=0x120, EX_true_taken=1, EX_taken=1.
  - Same op with BP_taken=1 and target 0x120 → EX_taken=0.
- **Multiply:** mul 0xFFFF_FFFF × 3 with MUL_FAST=0 → EX_busy high for exactly 32 cycles, then EX_alu_out=0xFFFF_FFFD.
  - Same with MUL_FAST=1 → result after 1 cycle.
- **Divide:** divu 100/7 → 14; remu 100/7 → 2; divu 9/0 → 0xFFFF_FFFF; remu 9/0 → 9.
  - A second EX_valid held during EX_busy is accepted only in the cycle EX_out_valid rises.
- **Flush:** assert EX_flush 10 cycles into a divu → EX_busy=0 next cycle and no EX_out_valid pulse.
  - A following sub 2−5 → 0xFFFF_FFFD.
- **New ops:** sra 0x8000_0000 by 4 → 0xF800_0000. slt −1 vs 1 → 1. ltu on the same operands → 0.
